t08_fetch_unit: RTL and testbench
=================================

# t08_fetch_unit

Parametrised instruction-fetch unit for the t08 core. It generates the PC and drives a request/acknowledge instruction-memory port. It presents each fetched instruction to decode under a valid/freeze handshake and resolves jump, branch and return redirects. Return addresses are held in a configurable-depth return-address stack (RAS), not a single register.

## Interface
Parameters:
- ADDR_W, 32: PC / memory address width.
- RESET_PC, 0: PC fetched first after reset.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- freeze  in  1  decode stall; instruction consumed when instr_valid && !freeze.
- jump  in  1  jump-and-link for consumed instruction.
- branch  in  1  taken branch for consumed instruction.
- ret  in  1  return for consumed instruction; target is RAS top.
- imm_offset  in  ADDR_W  signed offset, relative to instr_pc.
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  request address, bits [1:0] always 0.
- imem_ack  in  1  data valid; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  32  held instruction.
- instr_pc  out  ADDR_W  PC of held instruction.
- ret_address  out  ADDR_W  RAS top; 0 when empty.
- ras_empty  out  1  RAS holds no entries.
- ras_err  out  1  sticky: pop on empty RAS.

## Operation
- FSM states:
  - BOOT: reset state; goes to REQ on the first clock edge.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack, capture imem_rdata into instr and pc into instr_pc, then go to HOLD.
  - HOLD: instr_valid=1. On consume, compute next pc and go to REQ; otherwise stay in HOLD with all outputs stable.
- imem_addr stays stable while imem_req is high and ack is low. Only one request is outstanding at a time.
- Redirect inputs are sampled only in the consume cycle and are ignored otherwise.
- Next-pc priority:
  - ret: target = RAS top.
  - else jump: target = instr_pc + imm_offset.
  - else branch: target = instr_pc + imm_offset.
  - else instr_pc + 4.
- Arithmetic is two's-complement modulo 2^ADDR_W, so wrap-around is silent. Target bits [1:0] are forced to 0.
- RAS is a circular buffer with a pointer and a saturating count (0..RAS_DEPTH).
  - jump alone: push instr_pc+4. When full, overwrite the oldest entry; count stays RAS_DEPTH.
  - ret alone: pop. On empty, target = RESET_PC, count stays 0, ras_err is set.
  - jump and ret together: target = old top, then top is replaced with instr_pc+4; count unchanged. If empty, behave as a push and set ras_err.
- ras_err clears only on reset.
- Reset values:
  - State BOOT, pc = RESET_PC, RAS count 0.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - ret_address=0, ras_empty=1, ras_err=0.
- Reset asserted mid-request abandons the request: imem_req drops asynchronously and any later ack is ignored.

## Timing
- Reset release: BOOT in cycle 0, imem_req high in cycle 1.
- With same-cycle ack in cycle N, instr_valid is high in cycle N+1.
- Consume in cycle N: imem_req high with the new address in cycle N+1.
- Best-case throughput is one instruction per 2 cycles.
- RAS updates take effect at the consume edge, so ret_address reflects the push/pop in the following cycle.
- All outputs are registered, except imem_addr and imem_req, which are decoded from registered state only.

## Structure
- t08_fetch_pkg: state enum (BOOT, REQ, HOLD), INSTR_W=32, PC_STEP=4.
- Sub-module t08_ras: parameters ADDR_W, RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full, underflow pulse.
- t08_fetch_unit owns the FSM, the PC register, the instr/instr_pc registers and ras_err.

## Test plan
- Reset with RESET_PC=0x100 and ack tied high: imem_addr sequence 0x100, 0x104, 0x108 on consecutive REQ cycles; instr_pc matches each captured word.
- Hold freeze=1 for 5 cycles in HOLD: instr, instr_pc and instr_valid stable; no new imem_req.
- Consume at instr_pc=0x200 with jump, imm_offset=-0x10: next imem_addr 0x1F0, ret_address 0x204. Later ret: next imem_addr 0x204, ras_empty=1.
- With RAS_DEPTH=4, do 5 jumps, then 5 rets:
  - First 4 rets return the last 4 links, newest first.
  - 5th ret goes to RESET_PC and sets ras_err.
- jump and ret together with top=0x300 at instr_pc=0x400: target 0x300, ret_address becomes 0x404, count unchanged.
- Misc edge cases:
  - pc=0xFFFF_FFFC sequential: next address 0x0.
  - Assert nrst while awaiting ack: imem_req drops immediately.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/t08_fetch_pkg.sv
// Shared types and constants for the t08 instruction-fetch unit.
package t08_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

endpackage

// File: rtl/t08_fetch_if.sv
// Request/acknowledge instruction-memory port between the fetch unit and memory.
interface t08_fetch_if #(
   parameter int ADDR_W = 32
);
   import t08_fetch_pkg::*;

   logic               req;
   logic [ADDR_W-1:0]  addr;
   logic               ack;
   logic [INSTR_W-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/t08_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module t08_ras #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              underflow
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_next;
   logic [PTR_W-1:0]  ptr_prev;
   logic [PTR_W-1:0]  wr_idx;
   logic [CNT_W-1:0]  count;
   logic              replace;

   assign ptr_next  = ptr + PTR_ONE;
   assign ptr_prev  = ptr - PTR_ONE;
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign underflow = pop && empty;
   // push+pop on a non-empty stack rewrites the top in place
   assign replace   = push && pop && !empty;
   assign wr_idx    = replace ? ptr : ptr_next;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr   <= '0;
         count <= '0;
         top   <= '0;
      end else if (replace) begin
         top <= push_data;
      end else if (push) begin
         ptr <= ptr_next;
         top <= push_data;
         if (!full) begin
            count <= count + CNT_ONE;
         end
      end else if (pop && !empty) begin
         ptr   <= ptr_prev;
         count <= count - CNT_ONE;
         top   <= (count == CNT_ONE) ? '0 : mem[ptr_prev];
      end
   end

endmodule

// File: rtl/t08_fetch_unit.sv
// t08 instruction fetch: PC generation, single-outstanding imem requests,
// decode handshake and jump/branch/return redirects through a RAS.
//
// state | meaning
// BOOT  | reset state, leaves on the first clock edge
// REQ   | imem_req high at pc, waiting for ack
// HOLD  | instruction presented to decode, waiting for consume
module t08_fetch_unit
   import t08_fetch_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               freeze,
   input  logic               jump,
   input  logic               branch,
   input  logic               ret,
   input  logic [ADDR_W-1:0]  imm_offset,
   t08_fetch_if.master        imem,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  ret_address,
   output logic               ras_empty,
   output logic               ras_err
);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(PC_STEP);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] link;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_full;
   logic              ras_underflow;
   logic              consume;

   assign consume = (state == HOLD) && !freeze;
   assign link    = instr_pc + PC_INC;

   always_comb begin
      target = link;
      if (ret) begin
         target = ras_empty ? RESET_PC : ras_top;
      end else if (jump || branch) begin
         target = instr_pc + imm_offset;
      end
      target = target & ALIGN_MASK;
   end

   t08_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .nrst      (nrst),
      .push      (consume && jump),
      .pop       (consume && ret),
      .push_data (link),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full),
      .underflow (ras_underflow)
   );

   assign ret_address = ras_top;
   assign imem.req    = (state == REQ);
   assign imem.addr   = pc;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= BOOT;
         pc          <= RESET_PC & ALIGN_MASK;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         ras_err     <= 1'b0;
      end else begin
         if (ras_underflow) begin
            ras_err <= 1'b1;
         end
         case (state)
            BOOT: state <= REQ;
            REQ: begin
               if (imem.ack) begin
                  instr       <= imem.rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (!freeze) begin
                  pc          <= target;
                  instr_valid <= 1'b0;
                  state       <= REQ;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_t08_fetch_unit.sv
// Scoreboard bench for t08_fetch_unit: expected fetch PCs are queued when a
// consume is driven and popped when the fetched instruction appears.
module tb_t08_fetch_unit;
   import t08_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h100;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        freeze = 1'b1;
   logic        jump = 1'b0;
   logic        branch = 1'b0;
   logic        ret = 1'b0;
   logic        ack_en = 1'b1;
   logic [31:0] imm_offset = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] ret_address;
   logic        ras_empty;
   logic        ras_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ras_m[$];
   logic [31:0] cur;

   function automatic logic [31:0] rd(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
   endfunction

   t08_fetch_if #(.ADDR_W(32)) imem();
   assign imem.ack   = ack_en;
   assign imem.rdata = rd(imem.addr);

   t08_fetch_unit #(
      .ADDR_W    (32),
      .RESET_PC  (RST_PC),
      .RAS_DEPTH (4)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .freeze      (freeze),
      .jump        (jump),
      .branch      (branch),
      .ret         (ret),
      .imm_offset  (imm_offset),
      .imem        (imem),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .ret_address (ret_address),
      .ras_empty   (ras_empty),
      .ras_err     (ras_err)
   );

   always #5 clk = ~clk;

   // Waits (bounded) for the next held instruction; pops the expected PC.
   task automatic fetch(output logic ok, output logic [31:0] a, output logic [31:0] p,
                        output logic [31:0] w, output logic [31:0] e, output int lat);
      ok  = 1'b0;
      a   = 32'hxxxx_xxxx;
      lat = -1;
      e   = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      for (int i = 0; i < 20; i++) begin
         if (imem.req) a = imem.addr;
         if (instr_valid) begin
            ok  = 1'b1;
            lat = i;
            break;
         end
         @(negedge clk);
      end
      p = instr_pc;
      w = instr;
   endtask

   task automatic consume(input logic j, input logic b, input logic r,
                          input logic [31:0] imm, input logic [31:0] nxt);
      freeze = 1'b0; jump = j; branch = b; ret = r; imm_offset = imm;
      exp_q.push_back(nxt);
      @(negedge clk);
      freeze = 1'b1; jump = 1'b0; branch = 1'b0; ret = 1'b0; imm_offset = '0;
   endtask

   task automatic test_reset();
      logic ok; logic [31:0] a, p, w, e; int lat;
      nrst = 1'b1;
      #1 nrst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (imem.req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
          ret_address !== 32'h0 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: req=%b valid=%b instr=%h pc=%h ret=%h empty=%b err=%b required 0 0 0 0 0 1 0",
                  imem.req, instr_valid, instr, instr_pc, ret_address, ras_empty, ras_err);
      end
      nrst = 1'b1;
      exp_q.push_back(RST_PC);
      @(negedge clk);
      n_checks++;
      if (imem.req !== 1'b1 || imem.addr !== RST_PC) begin
         n_errors++;
         $display("FAIL boot_req: req=%b addr=%h required 1 %h", imem.req, imem.addr, RST_PC);
      end
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL first_fetch: ok=%b addr=%h pc=%h instr=%h required %h %h", ok, a, p, w, e, rd(e));
      end
      cur = e;
   endtask

   task automatic test_sequential();
      logic ok; logic [31:0] a, p, w, e; int lat;
      for (int k = 0; k < 2; k++) begin
         consume(1'b0, 1'b0, 1'b0, 32'h0, cur + 32'h4);
         fetch(ok, a, p, w, e, lat);
         n_checks++;
         if (!ok || lat != 1 || a !== e || p !== e || w !== rd(e)) begin
            n_errors++;
            $display("FAIL seq_fetch%0d: ok=%b lat=%0d addr=%h pc=%h instr=%h required lat 1 %h %h",
                     k, ok, lat, a, p, w, e, rd(e));
         end
         cur = e;
      end
   endtask

   task automatic test_freeze();
      logic [31:0] i0, p0, r0;
      i0 = instr; p0 = instr_pc; r0 = ret_address;
      jump = 1'b1; ret = 1'b1; imm_offset = 32'h40;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (instr_valid !== 1'b1 || instr !== rd(cur) || instr_pc !== cur || imem.req !== 1'b0 ||
             ret_address !== 32'h0 || i0 !== rd(cur) || p0 !== cur || r0 !== 32'h0) begin
            n_errors++;
            $display("FAIL freeze_hold%0d: valid=%b instr=%h pc=%h req=%b ret=%h required 1 %h %h 0 0",
                     k, instr_valid, instr, instr_pc, imem.req, ret_address, rd(cur), cur);
         end
      end
      jump = 1'b0; ret = 1'b0; imm_offset = '0;
   endtask

   task automatic test_jump_ret();
      logic ok; logic [31:0] a, p, w, e; int lat;
      consume(1'b0, 1'b1, 1'b0, 32'h200 - cur, 32'h200);
      fetch(ok, a, p, w, e, lat);
      consume(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h1F0);
      n_checks++;
      if (ok !== 1'b1 || p !== 32'h200 || ret_address !== 32'h204 || ras_empty !== 1'b0) begin
         n_errors++;
         $display("FAIL jump_link: ok=%b pc=%h ret=%h empty=%b required pc 200 ret 204 empty 0",
                  ok, p, ret_address, ras_empty);
      end
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL jump_target: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      consume(1'b0, 1'b0, 1'b1, 32'h0, 32'h204);
      n_checks++;
      if (ras_empty !== 1'b1 || ret_address !== 32'h0) begin
         n_errors++;
         $display("FAIL ret_pop: empty=%b ret=%h required 1 0", ras_empty, ret_address);
      end
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL ret_target: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      cur = e;
   endtask

   task automatic test_ras_overflow();
      logic ok; logic [31:0] a, p, w, e, tgt; int lat;
      ras_m.delete();
      for (int k = 0; k < 5; k++) begin
         tgt = cur + 32'h40;
         ras_m.push_front(cur + 32'h4);
         if (ras_m.size() > 4) void'(ras_m.pop_back());
         consume(1'b1, 1'b0, 1'b0, 32'h40, tgt);
         fetch(ok, a, p, w, e, lat);
         n_checks++;
         if (!ok || a !== e || p !== e) begin
            n_errors++;
            $display("FAIL ovf_jump%0d: ok=%b addr=%h pc=%h required %h", k, ok, a, p, e);
         end
         cur = e;
      end
      for (int k = 0; k < 5; k++) begin
         tgt = (ras_m.size() > 0) ? ras_m.pop_front() : RST_PC;
         n_checks++;
         if (ras_err !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_err_early%0d: ras_err=%b required 0", k, ras_err);
         end
         consume(1'b0, 1'b0, 1'b1, 32'h0, tgt);
         fetch(ok, a, p, w, e, lat);
         n_checks++;
         if (!ok || a !== e || p !== e || w !== rd(e)) begin
            n_errors++;
            $display("FAIL ovf_ret%0d: ok=%b addr=%h pc=%h required %h", k, ok, a, p, e);
         end
         cur = e;
      end
      n_checks++;
      if (ras_err !== 1'b1 || ras_empty !== 1'b1 || cur !== RST_PC) begin
         n_errors++;
         $display("FAIL underflow: ras_err=%b empty=%b pc=%h required 1 1 %h", ras_err, ras_empty, cur, RST_PC);
      end
   endtask

   task automatic test_jump_and_ret();
      logic ok; logic [31:0] a, p, w, e; int lat;
      consume(1'b0, 1'b1, 1'b0, 32'h2FC - cur, 32'h2FC);
      fetch(ok, a, p, w, e, lat);
      consume(1'b1, 1'b0, 1'b0, 32'h104, 32'h400);
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || p !== 32'h400 || ret_address !== 32'h300) begin
         n_errors++;
         $display("FAIL jr_setup: ok=%b pc=%h ret=%h required 400 300", ok, p, ret_address);
      end
      consume(1'b1, 1'b0, 1'b1, 32'h77, 32'h300);
      n_checks++;
      if (ret_address !== 32'h404 || ras_empty !== 1'b0) begin
         n_errors++;
         $display("FAIL jr_replace: ret=%h empty=%b required 404 0", ret_address, ras_empty);
      end
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL jr_target: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      consume(1'b0, 1'b0, 1'b1, 32'h0, 32'h404);
      n_checks++;
      if (ras_empty !== 1'b1) begin
         n_errors++;
         $display("FAIL jr_count: empty=%b required 1", ras_empty);
      end
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e) begin
         n_errors++;
         $display("FAIL jr_ret: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      cur = e;
   endtask

   task automatic test_wrap();
      logic ok; logic [31:0] a, p, w, e; int lat;
      consume(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC - cur, 32'hFFFF_FFFC);
      fetch(ok, a, p, w, e, lat);
      consume(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL wrap: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      consume(1'b0, 1'b1, 1'b0, 32'h13, 32'h10);
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e) begin
         n_errors++;
         $display("FAIL align: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
      cur = e;
   endtask

   task automatic test_reset_mid();
      logic ok; logic [31:0] a, p, w, e; int lat;
      ack_en = 1'b0;
      consume(1'b0, 1'b0, 1'b0, 32'h0, cur + 32'h4);
      @(negedge clk);
      n_checks++;
      if (imem.req !== 1'b1 || imem.addr !== cur + 32'h4) begin
         n_errors++;
         $display("FAIL await_ack: req=%b addr=%h required 1 %h", imem.req, imem.addr, cur + 32'h4);
      end
      nrst = 1'b0;
      #1;
      n_checks++;
      if (imem.req !== 1'b0) begin
         n_errors++;
         $display("FAIL async_drop: req=%b required 0", imem.req);
      end
      ack_en = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (imem.req !== 1'b0 || instr_valid !== 1'b0 || ras_err !== 1'b0) begin
         n_errors++;
         $display("FAIL abandoned: req=%b valid=%b err=%b required 0 0 0", imem.req, instr_valid, ras_err);
      end
      nrst = 1'b1;
      exp_q.delete();
      exp_q.push_back(RST_PC);
      fetch(ok, a, p, w, e, lat);
      n_checks++;
      if (!ok || a !== e || p !== e || w !== rd(e)) begin
         n_errors++;
         $display("FAIL restart: ok=%b addr=%h pc=%h required %h", ok, a, p, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_freeze();
      test_jump_ret();
      test_ras_overflow();
      test_jump_and_ret();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
